axi_arb_2to1_32: RTL and testbench



---
 rtl/axi_arb_2to1_32_if.sv | 83 ++++++++
 rtl/axi_arb_2to1_32.sv | 160 ++++++++++++++++
 tb/tb_axi_arb_2to1_32.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_arb_2to1_32_if.sv
// AXI4 (full) bundle shared by both requester ports and the downstream port
// of axi_arb_2to1_32. There are no ID signals because one transaction per
// path is in flight.
//   AW : awaddr awlen awsize awburst awlock awcache awprot awregion awqos
//        awvalid / awready
//   W  : wdata wstrb wlast wvalid / wready
//   B  : bresp bvalid / bready
//   AR : araddr arlen arsize arburst arlock arcache arprot arregion arqos
//        arvalid / arready
//   R  : rdata rresp rlast rvalid / rready
// Modports: master (drives requests) and slave (drives responses).
interface axi_arb_2to1_32_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic [3:0]        awregion;
  logic [3:0]        awqos;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arregion;
  logic [3:0]        arqos;
  logic              arvalid;
  logic              arready;

  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awregion, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arlock, arcache, arprot, arregion, arqos, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awregion, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arlock, arcache, arprot, arregion, arqos, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_arb_2to1_32.sv
// Two-requester round-robin arbiter in front of one AXI4 slave port.
// The write (AW/W/B) and read (AR/R) paths are arbitrated independently,
// each with one transaction in flight. Payloads are combinational muxes
// from the granted requester; the ungranted requester sees all-zero
// ready/valid/response outputs.
//   aclk    : clock for all ports
//   aresetn : asynchronous active-low reset
//   s0      : requester 0 (width-converter master side), slave modport
//   s1      : requester 1, slave modport
//   m       : shared downstream slave, master modport
module axi_arb_2to1_32 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  axi_arb_2to1_32_if.slave  s0,
  axi_arb_2to1_32_if.slave  s1,
  axi_arb_2to1_32_if.master m
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;
  // gnt: 0 = s0, 1 = s1. prev: requester granted last time on that path.
  logic w_gnt, w_gnt_nxt, w_prev, w_prev_nxt;
  logic r_gnt, r_gnt_nxt, r_prev, r_prev_nxt;

  logic w_addr_ph, w_data_ph, w_resp_ph, r_addr_ph, r_data_ph;
  logic aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;

  logic [ADDR_W-1:0] awaddr_sel, araddr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic [STRB_W-1:0] wstrb_sel;

  function automatic logic pick(input logic req0, input logic req1, input logic prev);
    return (req0 && req1) ? ~prev : req1;
  endfunction

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      w_gnt   <= 1'b0;
      w_prev  <= 1'b1;
      r_state <= R_IDLE;
      r_gnt   <= 1'b0;
      r_prev  <= 1'b1;
    end else begin
      w_state <= w_state_nxt;
      w_gnt   <= w_gnt_nxt;
      w_prev  <= w_prev_nxt;
      r_state <= r_state_nxt;
      r_gnt   <= r_gnt_nxt;
      r_prev  <= r_prev_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    w_gnt_nxt   = w_gnt;
    w_prev_nxt  = w_prev;
    case (w_state)
      W_IDLE: if (s0.awvalid || s1.awvalid) begin
        w_gnt_nxt   = pick(s0.awvalid, s1.awvalid, w_prev);
        w_prev_nxt  = w_gnt_nxt;
        w_state_nxt = W_ADDR;
      end
      W_ADDR:  if (aw_hs)     w_state_nxt = W_DATA;
      W_DATA:  if (w_last_hs) w_state_nxt = W_RESP;
      W_RESP:  if (b_hs)      w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    r_gnt_nxt   = r_gnt;
    r_prev_nxt  = r_prev;
    case (r_state)
      R_IDLE: if (s0.arvalid || s1.arvalid) begin
        r_gnt_nxt   = pick(s0.arvalid, s1.arvalid, r_prev);
        r_prev_nxt  = r_gnt_nxt;
        r_state_nxt = R_ADDR;
      end
      R_ADDR:  if (ar_hs)     r_state_nxt = R_DATA;
      R_DATA:  if (r_last_hs) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign w_addr_ph = (w_state == W_ADDR);
  assign w_data_ph = (w_state == W_DATA);
  assign w_resp_ph = (w_state == W_RESP);
  assign r_addr_ph = (r_state == R_ADDR);
  assign r_data_ph = (r_state == R_DATA);

  assign aw_hs     = m.awvalid && m.awready;
  assign w_last_hs = m.wvalid && m.wready && m.wlast;
  assign b_hs      = m.bvalid && m.bready;
  assign ar_hs     = m.arvalid && m.arready;
  assign r_last_hs = m.rvalid && m.rready && m.rlast;

  // Write address / data toward m
  assign awaddr_sel  = w_gnt ? s1.awaddr : s0.awaddr;
  assign wdata_sel   = w_gnt ? s1.wdata  : s0.wdata;
  assign wstrb_sel   = w_gnt ? s1.wstrb  : s0.wstrb;
  assign m.awaddr    = awaddr_sel;
  assign m.awlen     = w_gnt ? s1.awlen    : s0.awlen;
  assign m.awsize    = w_gnt ? s1.awsize   : s0.awsize;
  assign m.awburst   = w_gnt ? s1.awburst  : s0.awburst;
  assign m.awlock    = w_gnt ? s1.awlock   : s0.awlock;
  assign m.awcache   = w_gnt ? s1.awcache  : s0.awcache;
  assign m.awprot    = w_gnt ? s1.awprot   : s0.awprot;
  assign m.awregion  = w_gnt ? s1.awregion : s0.awregion;
  assign m.awqos     = w_gnt ? s1.awqos    : s0.awqos;
  assign m.awvalid   = w_addr_ph && (w_gnt ? s1.awvalid : s0.awvalid);
  assign m.wdata     = wdata_sel;
  assign m.wstrb     = wstrb_sel;
  assign m.wlast     = w_gnt ? s1.wlast : s0.wlast;
  assign m.wvalid    = w_data_ph && (w_gnt ? s1.wvalid : s0.wvalid);
  assign m.bready    = w_resp_ph && (w_gnt ? s1.bready : s0.bready);

  // Read address toward m
  assign araddr_sel  = r_gnt ? s1.araddr : s0.araddr;
  assign m.araddr    = araddr_sel;
  assign m.arlen     = r_gnt ? s1.arlen    : s0.arlen;
  assign m.arsize    = r_gnt ? s1.arsize   : s0.arsize;
  assign m.arburst   = r_gnt ? s1.arburst  : s0.arburst;
  assign m.arlock    = r_gnt ? s1.arlock   : s0.arlock;
  assign m.arcache   = r_gnt ? s1.arcache  : s0.arcache;
  assign m.arprot    = r_gnt ? s1.arprot   : s0.arprot;
  assign m.arregion  = r_gnt ? s1.arregion : s0.arregion;
  assign m.arqos     = r_gnt ? s1.arqos    : s0.arqos;
  assign m.arvalid   = r_addr_ph && (r_gnt ? s1.arvalid : s0.arvalid);
  assign m.rready    = r_data_ph && (r_gnt ? s1.rready : s0.rready);

  // Responses back to the requesters; the ungranted side sees zeros
  assign s0.awready  = w_addr_ph && !w_gnt && m.awready;
  assign s1.awready  = w_addr_ph &&  w_gnt && m.awready;
  assign s0.wready   = w_data_ph && !w_gnt && m.wready;
  assign s1.wready   = w_data_ph &&  w_gnt && m.wready;
  assign s0.bvalid   = w_resp_ph && !w_gnt && m.bvalid;
  assign s1.bvalid   = w_resp_ph &&  w_gnt && m.bvalid;
  assign s0.bresp    = (w_resp_ph && !w_gnt) ? m.bresp : '0;
  assign s1.bresp    = (w_resp_ph &&  w_gnt) ? m.bresp : '0;

  assign s0.arready  = r_addr_ph && !r_gnt && m.arready;
  assign s1.arready  = r_addr_ph &&  r_gnt && m.arready;
  assign s0.rvalid   = r_data_ph && !r_gnt && m.rvalid;
  assign s1.rvalid   = r_data_ph &&  r_gnt && m.rvalid;
  assign s0.rresp    = (r_data_ph && !r_gnt) ? m.rresp : '0;
  assign s1.rresp    = (r_data_ph &&  r_gnt) ? m.rresp : '0;
  assign s0.rdata    = (r_data_ph && !r_gnt) ? m.rdata : '0;
  assign s1.rdata    = (r_data_ph &&  r_gnt) ? m.rdata : '0;
  assign s0.rlast    = r_data_ph && !r_gnt && m.rlast;
  assign s1.rlast    = r_data_ph &&  r_gnt && m.rlast;
endmodule

// File: tb/tb_axi_arb_2to1_32.sv
// Scoreboard bench for axi_arb_2to1_32: requester tasks push expected
// transfers into queues, a negedge monitor pops and compares on every
// handshake seen at m and at s0/s1. A small downstream slave model returns
// rdata = araddr + beat index and bresp = OKAY.
`timescale 1ns/1ps
module tb_axi_arb_2to1_32;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi_arb_2to1_32_if #(.ADDR_W(32), .DATA_W(32)) s0 ();
  axi_arb_2to1_32_if #(.ADDR_W(32), .DATA_W(32)) s1 ();
  axi_arb_2to1_32_if #(.ADDR_W(32), .DATA_W(32)) m ();

  axi_arb_2to1_32 #(.ADDR_W(32), .DATA_W(32)) dut (
    .aclk(aclk), .aresetn(aresetn), .s0(s0), .s1(s1), .m(m)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- requester drive arrays ----------------
  logic [31:0] q_awaddr [2];
  logic [31:0] q_araddr [2];
  logic [31:0] q_wdata  [2];
  logic [7:0]  q_awlen  [2];
  logic [7:0]  q_arlen  [2];
  logic        q_awvalid[2];
  logic        q_wvalid [2];
  logic        q_wlast  [2];
  logic        q_bready [2];
  logic        q_arvalid[2];
  logic        q_rready [2];

  assign s0.awaddr = q_awaddr[0];  assign s1.awaddr = q_awaddr[1];
  assign s0.awlen  = q_awlen[0];   assign s1.awlen  = q_awlen[1];
  assign s0.awvalid = q_awvalid[0]; assign s1.awvalid = q_awvalid[1];
  assign s0.wdata  = q_wdata[0];   assign s1.wdata  = q_wdata[1];
  assign s0.wlast  = q_wlast[0];   assign s1.wlast  = q_wlast[1];
  assign s0.wvalid = q_wvalid[0];  assign s1.wvalid = q_wvalid[1];
  assign s0.bready = q_bready[0];  assign s1.bready = q_bready[1];
  assign s0.araddr = q_araddr[0];  assign s1.araddr = q_araddr[1];
  assign s0.arlen  = q_arlen[0];   assign s1.arlen  = q_arlen[1];
  assign s0.arvalid = q_arvalid[0]; assign s1.arvalid = q_arvalid[1];
  assign s0.rready = q_rready[0];  assign s1.rready = q_rready[1];

  assign s0.awsize = 3'd2;  assign s0.awburst = 2'b01; assign s0.awlock = 1'b0;
  assign s0.awcache = 4'd0; assign s0.awprot = 3'd0;   assign s0.awregion = 4'd0;
  assign s0.awqos = 4'd1;   assign s0.wstrb = 4'hF;
  assign s0.arsize = 3'd2;  assign s0.arburst = 2'b01; assign s0.arlock = 1'b0;
  assign s0.arcache = 4'd0; assign s0.arprot = 3'd0;   assign s0.arregion = 4'd0;
  assign s0.arqos = 4'd1;
  assign s1.awsize = 3'd2;  assign s1.awburst = 2'b01; assign s1.awlock = 1'b0;
  assign s1.awcache = 4'd0; assign s1.awprot = 3'd0;   assign s1.awregion = 4'd0;
  assign s1.awqos = 4'd2;   assign s1.wstrb = 4'hF;
  assign s1.arsize = 3'd2;  assign s1.arburst = 2'b01; assign s1.arlock = 1'b0;
  assign s1.arcache = 4'd0; assign s1.arprot = 3'd0;   assign s1.arregion = 4'd0;
  assign s1.arqos = 4'd2;

  function automatic logic awready_of(input int unsigned w); return w != 0 ? s1.awready : s0.awready; endfunction
  function automatic logic wready_of(input int unsigned w);  return w != 0 ? s1.wready  : s0.wready;  endfunction
  function automatic logic bvalid_of(input int unsigned w);  return w != 0 ? s1.bvalid  : s0.bvalid;  endfunction
  function automatic logic arready_of(input int unsigned w); return w != 0 ? s1.arready : s0.arready; endfunction
  function automatic logic rvalid_of(input int unsigned w);  return w != 0 ? s1.rvalid  : s0.rvalid;  endfunction
  function automatic logic rlast_of(input int unsigned w);   return w != 0 ? s1.rlast   : s0.rlast;   endfunction

  // ---------------- downstream slave model ----------------
  logic        rd_active, rd_rand, rd_hs;
  logic [31:0] rd_addr;
  logic [7:0]  rd_len, rd_beat, rd_nbeat;

  assign m.awready = 1'b1;
  assign m.wready  = 1'b1;
  assign m.arready = 1'b1;
  assign m.bresp   = 2'b00;
  assign m.rresp   = 2'b00;
  assign rd_hs     = m.rvalid && m.rready;
  assign rd_nbeat  = rd_hs ? rd_beat + 8'd1 : rd_beat;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) m.bvalid <= 1'b0;
    else if (m.wvalid && m.wready && m.wlast) m.bvalid <= 1'b1;
    else if (m.bvalid && m.bready) m.bvalid <= 1'b0;
  end

  // Once rvalid is up it holds until accepted; with rd_rand it may idle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_active <= 1'b0; rd_addr <= '0; rd_len <= '0; rd_beat <= '0;
      m.rvalid <= 1'b0; m.rlast <= 1'b0; m.rdata <= '0;
    end else if (m.arvalid && m.arready) begin
      rd_active <= 1'b1; rd_addr <= m.araddr; rd_len <= m.arlen; rd_beat <= '0;
    end else if (rd_hs && m.rlast) begin
      rd_active <= 1'b0; m.rvalid <= 1'b0; m.rlast <= 1'b0;
    end else if (rd_active && (rd_hs || !m.rvalid)) begin
      rd_beat <= rd_nbeat;
      if (!rd_rand || $urandom_range(0, 1) == 1) begin
        m.rvalid <= 1'b1;
        m.rdata  <= rd_addr + {24'h0, rd_nbeat};
        m.rlast  <= (rd_nbeat == rd_len);
      end else begin
        m.rvalid <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed { logic [31:0] addr; logic [7:0] len; logic [3:0] qos; } ax_t;
  typedef struct packed { logic [31:0] data; logic last; } beat_t;
  ax_t   exp_aw[$], exp_ar[$];
  beat_t exp_w[$], exp_r0[$], exp_r1[$];
  logic [1:0] exp_b0[$], exp_b1[$];
  logic quiet_s1 = 1'b0;

  always @(negedge aclk) begin
    ax_t a; beat_t b; logic [1:0] r;
    if (aresetn) begin
      if (m.awvalid && m.awready) begin
        if (exp_aw.size() == 0) check("aw_unexpected", 64'(m.awaddr), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          a = exp_aw.pop_front();
          check("aw_addr", 64'(m.awaddr), 64'(a.addr));
          check("aw_len", 64'(m.awlen), 64'(a.len));
          check("aw_qos", 64'(m.awqos), 64'(a.qos));
        end
      end
      if (m.arvalid && m.arready) begin
        if (exp_ar.size() == 0) check("ar_unexpected", 64'(m.araddr), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          a = exp_ar.pop_front();
          check("ar_addr", 64'(m.araddr), 64'(a.addr));
          check("ar_len", 64'(m.arlen), 64'(a.len));
          check("ar_qos", 64'(m.arqos), 64'(a.qos));
        end
      end
      if (m.wvalid && m.wready) begin
        if (exp_w.size() == 0) check("w_unexpected", 64'(m.wdata), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          b = exp_w.pop_front();
          check("w_beat", 64'({m.wdata, m.wlast}), 64'(b));
        end
      end
      if (s0.rvalid && s0.rready) begin
        if (exp_r0.size() == 0) check("r0_unexpected", 64'(s0.rdata), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin b = exp_r0.pop_front(); check("r0_beat", 64'({s0.rdata, s0.rlast}), 64'(b)); end
      end
      if (s1.rvalid && s1.rready) begin
        if (exp_r1.size() == 0) check("r1_unexpected", 64'(s1.rdata), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin b = exp_r1.pop_front(); check("r1_beat", 64'({s1.rdata, s1.rlast}), 64'(b)); end
      end
      if (s0.bvalid && s0.bready) begin
        if (exp_b0.size() == 0) check("b0_unexpected", 64'(s0.bresp), 64'hFF);
        else begin r = exp_b0.pop_front(); check("b0_resp", 64'(s0.bresp), 64'(r)); end
      end
      if (s1.bvalid && s1.bready) begin
        if (exp_b1.size() == 0) check("b1_unexpected", 64'(s1.bresp), 64'hFF);
        else begin r = exp_b1.pop_front(); check("b1_resp", 64'(s1.bresp), 64'(r)); end
      end
      if (quiet_s1)
        check("s1_quiet", 64'({s1.awready, s1.wready, s1.arready, s1.bvalid, s1.rvalid,
                               s1.bresp, s1.rresp, s1.rdata, s1.rlast}), 64'd0);
    end
  end

  // ---------------- requester tasks ----------------
  task automatic do_write(input int unsigned who, input logic [31:0] addr, input logic [7:0] len,
                          input logic [31:0] base, input bit chk_lat, input bit early,
                          input int abort_beat);
    int unsigned n;
    bit ok;
    @(posedge aclk); #1;
    q_bready[who] = 1'b1;
    if (early) begin
      q_wvalid[who] = 1'b1; q_wdata[who] = base; q_wlast[who] = (len == 8'd0);
      repeat (2) begin
        @(negedge aclk);
        check("early_wready", 64'(wready_of(who)), 64'd0);
        check("early_m_wvalid", 64'(m.wvalid), 64'd0);
      end
      @(posedge aclk); #1;
    end
    q_awaddr[who] = addr; q_awlen[who] = len; q_awvalid[who] = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge aclk); n++;
      if (early) begin
        check("early_wready_aw", 64'(wready_of(who)), 64'd0);
        check("early_m_wvalid_aw", 64'(m.wvalid), 64'd0);
      end
      if (awready_of(who)) ok = 1'b1;
    end
    if (!ok) begin check("aw_timeout", 64'd0, 64'd1); return; end
    if (chk_lat) check("aw_latency", 64'(n), 64'd2);
    for (int unsigned i = 0; i <= 32'(len); i++)
      exp_w.push_back(beat_t'{data: base * (i + 1), last: (i == 32'(len))});
    @(posedge aclk); #1;
    q_awvalid[who] = 1'b0;
    for (int unsigned i = 0; i <= 32'(len); i++) begin
      q_wvalid[who] = 1'b1; q_wdata[who] = base * (i + 1); q_wlast[who] = (i == 32'(len));
      if (abort_beat == int'(i)) begin
        #2 aresetn = 1'b0;
        #1 check("rst_m_valids", 64'({m.awvalid, m.wvalid, m.arvalid, m.bvalid, m.rvalid}), 64'd0);
        q_wvalid[who] = 1'b0; q_wlast[who] = 1'b0; q_bready[who] = 1'b0;
        exp_w.delete();
        return;
      end
      n = 0; ok = 1'b0;
      while (!ok && n < 200) begin
        @(negedge aclk); n++;
        if (wready_of(who)) ok = 1'b1;
      end
      if (!ok) begin check("w_timeout", 64'd0, 64'd1); return; end
      if (chk_lat) check("w_beat_gap", 64'(n), 64'd1);
      @(posedge aclk); #1;
    end
    q_wvalid[who] = 1'b0; q_wlast[who] = 1'b0;
    if (who != 0) exp_b1.push_back(2'b00); else exp_b0.push_back(2'b00);
    n = 0; ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge aclk); n++;
      if (bvalid_of(who)) ok = 1'b1;
    end
    if (!ok) check("b_timeout", 64'd0, 64'd1);
    @(posedge aclk); #1;
    q_bready[who] = 1'b0;
  endtask

  task automatic do_read(input int unsigned who, input logic [31:0] addr, input logic [7:0] len,
                         input bit chk_lat, input bit toggle);
    int unsigned n;
    bit ok;
    for (int unsigned i = 0; i <= 32'(len); i++) begin
      if (who != 0) exp_r1.push_back(beat_t'{data: addr + i, last: (i == 32'(len))});
      else          exp_r0.push_back(beat_t'{data: addr + i, last: (i == 32'(len))});
    end
    @(posedge aclk); #1;
    q_araddr[who] = addr; q_arlen[who] = len; q_arvalid[who] = 1'b1; q_rready[who] = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge aclk); n++;
      if (arready_of(who)) ok = 1'b1;
    end
    if (!ok) begin check("ar_timeout", 64'd0, 64'd1); return; end
    if (chk_lat) check("ar_latency", 64'(n), 64'd2);
    @(posedge aclk); #1;
    q_arvalid[who] = 1'b0;
    n = 0; ok = 1'b0;
    while (!ok && n < 500) begin
      if (toggle) q_rready[who] = ~q_rready[who];
      @(negedge aclk); n++;
      if (rvalid_of(who) && q_rready[who] && rlast_of(who)) ok = 1'b1;
      @(posedge aclk); #1;
    end
    if (!ok) check("r_timeout", 64'd0, 64'd1);
    q_rready[who] = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int unsigned i = 0; i < 2; i++) begin
      q_awaddr[i] = '0; q_araddr[i] = '0; q_wdata[i] = '0; q_awlen[i] = '0; q_arlen[i] = '0;
      q_awvalid[i] = 1'b0; q_wvalid[i] = 1'b0; q_wlast[i] = 1'b0;
      q_bready[i] = 1'b0; q_arvalid[i] = 1'b0; q_rready[i] = 1'b0;
    end
    rd_rand = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_m_out", 64'({m.awvalid, m.wvalid, m.arvalid, m.bready, m.rready}), 64'd0);
    check("rst_s_out", 64'({s0.awready, s0.wready, s0.arready, s0.bvalid, s0.rvalid,
                            s1.awready, s1.wready, s1.arready, s1.bvalid, s1.rvalid}), 64'd0);
    aresetn = 1'b1;

    // single 4-beat write from s0, s1 must stay quiet
    quiet_s1 = 1'b1;
    exp_aw.push_back(ax_t'{addr: 32'h0000_0100, len: 8'd3, qos: 4'd1});
    do_write(0, 32'h0000_0100, 8'd3, 32'h11, 1'b1, 1'b0, -1);
    quiet_s1 = 1'b0;

    // simultaneous reads, three rounds: strict alternation s0/s1
    for (int unsigned k = 0; k < 3; k++) begin
      exp_ar.push_back(ax_t'{addr: 32'h1000, len: 8'd0, qos: 4'd1});
      exp_ar.push_back(ax_t'{addr: 32'h2000, len: 8'd0, qos: 4'd2});
    end
    fork
      begin repeat (3) do_read(0, 32'h1000, 8'd0, 1'b0, 1'b0); end
      begin repeat (3) do_read(1, 32'h2000, 8'd0, 1'b0, 1'b0); end
    join

    // concurrent write (s0) and read (s1)
    exp_aw.push_back(ax_t'{addr: 32'h3000, len: 8'd7, qos: 4'd1});
    exp_ar.push_back(ax_t'{addr: 32'h4000, len: 8'd7, qos: 4'd2});
    fork
      do_write(0, 32'h3000, 8'd7, 32'h0101_0101, 1'b1, 1'b0, -1);
      do_read(1, 32'h4000, 8'd7, 1'b1, 1'b0);
    join

    // early W from s1
    exp_aw.push_back(ax_t'{addr: 32'h5000, len: 8'd1, qos: 4'd2});
    do_write(1, 32'h5000, 8'd1, 32'hA5, 1'b1, 1'b1, -1);

    // len-15 read with random rvalid and alternating rready
    rd_rand = 1'b1;
    exp_ar.push_back(ax_t'{addr: 32'h6000, len: 8'd15, qos: 4'd1});
    do_read(0, 32'h6000, 8'd15, 1'b1, 1'b1);
    rd_rand = 1'b0;

    // reset during beat 3 of an 8-beat write
    exp_aw.push_back(ax_t'{addr: 32'h7000, len: 8'd7, qos: 4'd1});
    do_write(0, 32'h7000, 8'd7, 32'h10, 1'b1, 1'b0, 2);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;

    // first tie after reset goes to s0 on both paths
    exp_aw.push_back(ax_t'{addr: 32'h8000, len: 8'd0, qos: 4'd1});
    exp_aw.push_back(ax_t'{addr: 32'h9000, len: 8'd0, qos: 4'd2});
    exp_ar.push_back(ax_t'{addr: 32'hA000, len: 8'd0, qos: 4'd1});
    exp_ar.push_back(ax_t'{addr: 32'hB000, len: 8'd0, qos: 4'd2});
    fork
      do_write(0, 32'h8000, 8'd0, 32'h77, 1'b0, 1'b0, -1);
      do_write(1, 32'h9000, 8'd0, 32'h99, 1'b0, 1'b0, -1);
      do_read(0, 32'hA000, 8'd0, 1'b0, 1'b0);
      do_read(1, 32'hB000, 8'd0, 1'b0, 1'b0);
    join

    repeat (4) @(posedge aclk);
    check("queues_drained", 64'(exp_aw.size() + exp_ar.size() + exp_w.size() + exp_r0.size() +
                                exp_r1.size() + exp_b0.size() + exp_b1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
